uart_receiver: RTL and testbench

- Minimal serial-to-parallel receiver for the bring-up UART path; samples `rx` once per `clk` rising edge, with no oversampling and one bit per clock.
- A low level on idle `rx` is the start bit. The next DATA_BITS samples shift into `data`, MSB-first: each new bit enters at bit 0 and older bits move left.
- `rdy` flags a completed word and holds until the next start bit.
- Sits between the `rx` pin (already synchronised upstream) and the consumer logic.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_receiver.sv | 81 ++++++++
 tb/tb_uart_receiver.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the bring-up UART path (receiver now,
// transmitter later).
//   uart_state_t      - two-state frame FSM encoding (IDLE, DATA)
//   DATA_BITS_DEFAULT - default number of data bits per frame
package uart_pkg;

  localparam int DATA_BITS_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } uart_state_t;

endpackage

// File: rtl/uart_receiver.sv
// uart_receiver: minimal serial-to-parallel receiver, one bit per clk edge,
// no oversampling, no stop-bit check, MSB-first shift into data[0].
// Ports:
//   clk  - system clock, all state updates on the rising edge
//   rst  - asynchronous active-high reset
//   rx   - serial line (pre-synchronised), idle high, start bit low
//   rdy  - high once a full word has been shifted in; cleared by next start
//   data - shift register contents, visible at all times (partial words too)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a low sample on rx; data/rdy hold
// DATA  | shifting DATA_BITS samples into data; cnt tracks the bit index
//
// DATA_BITS must be at least 2 (the shift and counter widths assume it).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] data
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  uart_state_t          state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 rdy_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      data  <= '0;
      rdy   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      data  <= data_nxt;
      rdy   <= rdy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data;
    rdy_nxt   = rdy;
    unique case (state)
      IDLE: begin
        // The previous word is deliberately left in data so a late reader
        // still sees it; only rdy drops on a new start.
        if (!rx) begin
          state_nxt = DATA;
          cnt_nxt   = '0;
          rdy_nxt   = 1'b0;
        end
      end
      DATA: begin
        data_nxt = {data[DATA_BITS-2:0], rx};
        if (cnt == LAST_BIT) begin
          // Return straight to IDLE: the following edge may already be
          // the next start bit (no stop-bit slot).
          state_nxt = IDLE;
          rdy_nxt   = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rdy;
  logic [7:0] data;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic       rx;
    logic [7:0] exp_data;
    logic       exp_rdy;
  } vec_t;

  vec_t vecs[$];

  uart_receiver #(.DATA_BITS(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rdy  (rdy),
    .data (data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] exp_d, input logic exp_r);
    compared++;
    if (data !== exp_d || rdy !== exp_r) begin
      mismatched++;
      $display("FAIL %s: data=0x%02h rdy=%b, expected data=0x%02h rdy=%b",
               name, data, rdy, exp_d, exp_r);
    end
  endtask

  task automatic push(input logic r, input logic [7:0] d, input logic rd);
    vec_t v;
    v.rx = r; v.exp_data = d; v.exp_rdy = rd;
    vecs.push_back(v);
  endtask

  // One vector per clock: drive on the falling edge, check 1 time unit
  // after the rising edge that samples it.
  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      @(negedge clk);
      rx = vecs[i].rx;
      @(posedge clk);
      #1;
      check($sformatf("%s_vec%0d", tag, i), vecs[i].exp_data, vecs[i].exp_rdy);
    end
    vecs.delete();
  endtask

  initial begin
    // Reset held across edges with rx low: outputs must stay cleared.
    rst = 1'b1;
    rx  = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_hold", 8'h00, 1'b0);
    @(negedge clk);
    rx  = 1'b1;
    rst = 1'b0;

    // Idle after reset.
    repeat (10) push(1'b1, 8'h00, 1'b0);
    // Partial frame then completion: bits 1,1,1,0,0,1,1,1 -> 0xE7.
    push(1'b0, 8'h00, 1'b0);
    push(1'b1, 8'h01, 1'b0);
    push(1'b1, 8'h03, 1'b0);
    push(1'b1, 8'h07, 1'b0);
    push(1'b0, 8'h0E, 1'b0);
    push(1'b0, 8'h1C, 1'b0);
    push(1'b1, 8'h39, 1'b0);
    push(1'b1, 8'h73, 1'b0);
    push(1'b1, 8'hE7, 1'b1);
    // rdy holds in idle.
    repeat (10) push(1'b1, 8'hE7, 1'b1);
    // Frame 1,1,1,0,0,0,0,0 over stale data -> 0xE0.
    push(1'b0, 8'hE7, 1'b0);
    push(1'b1, 8'hCF, 1'b0);
    push(1'b1, 8'h9F, 1'b0);
    push(1'b1, 8'h3F, 1'b0);
    push(1'b0, 8'h7E, 1'b0);
    push(1'b0, 8'hFC, 1'b0);
    push(1'b0, 8'hF8, 1'b0);
    push(1'b0, 8'hF0, 1'b0);
    push(1'b0, 8'hE0, 1'b1);
    // Back-to-back start on the very next edge; data not cleared.
    push(1'b0, 8'hE0, 1'b0);
    push(1'b1, 8'hC1, 1'b0);
    push(1'b0, 8'h82, 1'b0);
    push(1'b1, 8'h05, 1'b0);
    push(1'b1, 8'h0B, 1'b0);
    push(1'b0, 8'h16, 1'b0);
    push(1'b1, 8'h2D, 1'b0);
    push(1'b0, 8'h5A, 1'b0);
    push(1'b1, 8'hB5, 1'b1);
    push(1'b1, 8'hB5, 1'b1);
    // Single low sample in idle is a start; then 4 data bits 1,0,1,1.
    push(1'b0, 8'hB5, 1'b0);
    push(1'b1, 8'h6B, 1'b0);
    push(1'b0, 8'hD6, 1'b0);
    push(1'b1, 8'hAD, 1'b0);
    push(1'b1, 8'h5B, 1'b0);
    run_vecs("main");

    // Async reset between edges mid-frame: clears without a clock edge.
    #2 rst = 1'b1;
    #1 check("async_reset", 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;

    // Full frame 0xA5 after reset; partial word visible, rdy on 8th bit.
    push(1'b1, 8'h00, 1'b0);
    push(1'b0, 8'h00, 1'b0);
    push(1'b1, 8'h01, 1'b0);
    push(1'b0, 8'h02, 1'b0);
    push(1'b1, 8'h05, 1'b0);
    push(1'b0, 8'h0A, 1'b0);
    push(1'b0, 8'h14, 1'b0);
    push(1'b1, 8'h29, 1'b0);
    push(1'b0, 8'h52, 1'b0);
    push(1'b1, 8'hA5, 1'b1);
    repeat (3) push(1'b1, 8'hA5, 1'b1);
    run_vecs("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
